// File: rtl/corevx_mem_arbiter.sv
// Two-port Avalon-MM memory arbiter: port 0 = data cache, port 1 = instruction cache.
// Round-robin grant, held for a whole read or write burst; read beats are routed
// back to the owning port only.
`timescale 1ns/1ps
module corevx_mem_arbiter #(
    parameter int unsigned ADDR_W  = 34,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BURST_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    // port 0 (data cache)
    input  logic [ADDR_W-1:0]   p0_address,
    input  logic [BURST_W-1:0]  p0_burstcount,
    input  logic                p0_read,
    input  logic                p0_write,
    input  logic [DATA_W-1:0]   p0_writedata,
    input  logic [DATA_W/8-1:0] p0_byteenable,
    output logic                p0_waitrequest,
    output logic                p0_readdatavalid,
    output logic [DATA_W-1:0]   p0_readdata,
    output logic [1:0]          p0_response,
    // port 1 (instruction cache)
    input  logic [ADDR_W-1:0]   p1_address,
    input  logic [BURST_W-1:0]  p1_burstcount,
    input  logic                p1_read,
    input  logic                p1_write,
    input  logic [DATA_W-1:0]   p1_writedata,
    input  logic [DATA_W/8-1:0] p1_byteenable,
    output logic                p1_waitrequest,
    output logic                p1_readdatavalid,
    output logic [DATA_W-1:0]   p1_readdata,
    output logic [1:0]          p1_response,
    // memory side
    output logic [ADDR_W-1:0]   m_address,
    output logic [BURST_W-1:0]  m_burstcount,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic                m_readdatavalid,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic [1:0]          m_response
);

    typedef enum logic [1:0] {IDLE, READ_CMD, READ_DATA, WRITE} state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_grant_q, last_grant_d;
    logic [BURST_W-1:0]   beats_left_q, beats_left_d;

    logic                 sel;
    logic                 sel_rd, sel_wr;
    logic [ADDR_W-1:0]    sel_addr;
    logic [BURST_W-1:0]   sel_bc, bc_eff;
    logic [DATA_W-1:0]    sel_wd;
    logic [DATA_W/8-1:0]  sel_be;

    // Port selection: arbitrate in IDLE, otherwise follow the locked owner.
    always_comb begin
        sel = owner_q;
        if (state_q == IDLE) begin
            if ((p0_read | p0_write) && (p1_read | p1_write)) begin
                sel = ~last_grant_q;
            end else begin
                sel = p1_read | p1_write;
            end
        end
        sel_rd   = sel ? p1_read       : p0_read;
        sel_wr   = sel ? p1_write      : p0_write;
        sel_addr = sel ? p1_address    : p0_address;
        sel_bc   = sel ? p1_burstcount : p0_burstcount;
        sel_wd   = sel ? p1_writedata  : p0_writedata;
        sel_be   = sel ? p1_byteenable : p0_byteenable;
        bc_eff   = (sel_bc == '0) ? BURST_W'(1) : sel_bc;
    end

    // Next-state and output decode; read takes precedence over a simultaneous write.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_grant_d     = last_grant_q;
        beats_left_d     = beats_left_q;
        m_address        = '0;
        m_burstcount     = '0;
        m_read           = 1'b0;
        m_write          = 1'b0;
        m_writedata      = '0;
        m_byteenable     = '0;
        p0_waitrequest   = 1'b1;
        p1_waitrequest   = 1'b1;
        p0_readdatavalid = 1'b0;
        p1_readdatavalid = 1'b0;
        p0_readdata      = '0;
        p1_readdata      = '0;
        p0_response      = 2'b00;
        p1_response      = 2'b00;

        case (state_q)
            IDLE, READ_CMD: begin
                if (sel_rd || (state_q == IDLE && sel_wr)) begin
                    m_address    = sel_addr;
                    m_burstcount = bc_eff;
                    m_read       = sel_rd;
                    m_write      = sel_wr & ~sel_rd;
                    m_writedata  = sel_wd;
                    m_byteenable = sel_be;
                    if (sel) p1_waitrequest = m_waitrequest;
                    else     p0_waitrequest = m_waitrequest;
                    owner_d = sel;
                    if (!m_waitrequest) begin
                        if (sel_rd) begin
                            state_d      = READ_DATA;
                            beats_left_d = bc_eff;
                        end else begin
                            beats_left_d = bc_eff - BURST_W'(1);
                            if (bc_eff == BURST_W'(1)) last_grant_d = sel;
                            else                       state_d      = WRITE;
                        end
                    end else if (sel_rd) begin
                        state_d = READ_CMD;
                    end
                end else if (state_q == READ_CMD) begin
                    // Owner withdrew its stalled read; release the lock.
                    state_d = IDLE;
                end
            end
            READ_DATA: begin
                if (m_readdatavalid) begin
                    if (owner_q) begin
                        p1_readdatavalid = 1'b1;
                        p1_readdata      = m_readdata;
                        p1_response      = m_response;
                    end else begin
                        p0_readdatavalid = 1'b1;
                        p0_readdata      = m_readdata;
                        p0_response      = m_response;
                    end
                    beats_left_d = beats_left_q - BURST_W'(1);
                    if (beats_left_q <= BURST_W'(1)) begin
                        beats_left_d = '0;
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end
                end
            end
            WRITE: begin
                m_address    = sel_addr;
                m_burstcount = bc_eff;
                m_write      = sel_wr;
                m_writedata  = sel_wd;
                m_byteenable = sel_be;
                if (owner_q) p1_waitrequest = m_waitrequest;
                else         p0_waitrequest = m_waitrequest;
                if (sel_wr && !m_waitrequest) begin
                    beats_left_d = beats_left_q - BURST_W'(1);
                    if (beats_left_q <= BURST_W'(1)) begin
                        beats_left_d = '0;
                        state_d      = IDLE;
                        last_grant_d = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; async reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beats_left_q <= beats_left_d;
        end
    end

endmodule

// File: tb/tb_corevx_mem_arbiter.sv
// Directed bench for corevx_mem_arbiter: cycle-by-cycle vector table plus
// hand-written burst, write-stall, error-response and reset sequences.
`timescale 1ns/1ps
module tb_corevx_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] p0_address, p1_address, m_address;
    logic [4:0]  p0_burstcount, p1_burstcount, m_burstcount;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [31:0] p0_writedata, p1_writedata, m_writedata;
    logic [3:0]  p0_byteenable, p1_byteenable, m_byteenable;
    logic        p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
    logic [31:0] p0_readdata, p1_readdata, m_readdata;
    logic [1:0]  p0_response, p1_response, m_response;
    logic        m_read, m_write, m_waitrequest, m_readdatavalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    corevx_mem_arbiter #(.ADDR_W(34), .DATA_W(32), .BURST_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_address(p0_address), .p0_burstcount(p0_burstcount), .p0_read(p0_read),
        .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_byteenable(p0_byteenable),
        .p0_waitrequest(p0_waitrequest), .p0_readdatavalid(p0_readdatavalid),
        .p0_readdata(p0_readdata), .p0_response(p0_response),
        .p1_address(p1_address), .p1_burstcount(p1_burstcount), .p1_read(p1_read),
        .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_byteenable(p1_byteenable),
        .p1_waitrequest(p1_waitrequest), .p1_readdatavalid(p1_readdatavalid),
        .p1_readdata(p1_readdata), .p1_response(p1_response),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdatavalid(m_readdatavalid),
        .m_readdata(m_readdata), .m_response(m_response)
    );

    typedef struct {
        logic        rd0, wr0; logic [33:0] addr0; logic [4:0] bc0;
        logic        rd1;      logic [33:0] addr1; logic [4:0] bc1;
        logic        mw, rdv;  logic [31:0] rdata; logic [1:0] resp;
        logic        e_mrd, e_mwr; logic [33:0] e_maddr; logic [4:0] e_mbc;
        logic        e_w0, e_w1, e_v0, e_v1;
        logic [31:0] e_d0, e_d1;
        logic [1:0]  e_r0, e_r1;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        p0_address = '0; p0_burstcount = '0; p0_read = 1'b0; p0_write = 1'b0;
        p0_writedata = '0; p0_byteenable = '0;
        p1_address = '0; p1_burstcount = '0; p1_read = 1'b0; p1_write = 1'b0;
        p1_writedata = '0; p1_byteenable = '0;
        m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0; m_response = 2'b00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wdat [4];
        logic [3:0]  wbe  [4];
        int beats;
        int k;

        // rd0 wr0 addr0 bc0 | rd1 addr1 bc1 | mw rdv rdata resp | e_mrd e_mwr e_maddr e_mbc | e_w0 e_w1 e_v0 e_v1 | e_d0 e_d1 | e_r0 e_r1
        vecs[0]  = '{1'b1,1'b0,34'h100,5'd2, 1'b1,34'h200,5'd1, 1'b0,1'b0,32'h0,2'b00,        1'b1,1'b0,34'h100,5'd2, 1'b0,1'b1,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};
        vecs[1]  = '{1'b0,1'b0,34'h0,5'd0,   1'b1,34'h200,5'd1, 1'b0,1'b1,32'h11,2'b00,       1'b0,1'b0,34'h0,5'd0,   1'b1,1'b1,1'b1,1'b0, 32'h11,32'h0,       2'b00,2'b00};
        vecs[2]  = '{1'b0,1'b0,34'h0,5'd0,   1'b1,34'h200,5'd1, 1'b0,1'b1,32'h22,2'b00,       1'b0,1'b0,34'h0,5'd0,   1'b1,1'b1,1'b1,1'b0, 32'h22,32'h0,       2'b00,2'b00};
        vecs[3]  = '{1'b1,1'b0,34'h300,5'd1, 1'b1,34'h200,5'd1, 1'b0,1'b0,32'h0,2'b00,        1'b1,1'b0,34'h200,5'd1, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};
        vecs[4]  = '{1'b1,1'b0,34'h300,5'd1, 1'b1,34'h400,5'd1, 1'b0,1'b1,32'h33,2'b00,       1'b0,1'b0,34'h0,5'd0,   1'b1,1'b1,1'b0,1'b1, 32'h0,32'h33,       2'b00,2'b00};
        vecs[5]  = '{1'b1,1'b0,34'h300,5'd1, 1'b1,34'h400,5'd1, 1'b0,1'b0,32'h0,2'b00,        1'b1,1'b0,34'h300,5'd1, 1'b0,1'b1,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};
        vecs[6]  = '{1'b0,1'b0,34'h0,5'd0,   1'b1,34'h400,5'd1, 1'b0,1'b1,32'hBEAFDEAD,2'b00, 1'b0,1'b0,34'h0,5'd0,   1'b1,1'b1,1'b1,1'b0, 32'hBEAFDEAD,32'h0, 2'b00,2'b00};
        vecs[7]  = '{1'b0,1'b0,34'h0,5'd0,   1'b0,34'h0,5'd0,   1'b0,1'b1,32'h55,2'b00,       1'b0,1'b0,34'h0,5'd0,   1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};
        vecs[8]  = '{1'b1,1'b0,34'h0,5'd1,   1'b0,34'h0,5'd0,   1'b1,1'b0,32'h0,2'b00,        1'b1,1'b0,34'h0,5'd1,   1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};
        vecs[9]  = '{1'b1,1'b0,34'h0,5'd1,   1'b1,34'h400,5'd1, 1'b1,1'b0,32'h0,2'b00,        1'b1,1'b0,34'h0,5'd1,   1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};
        vecs[10] = '{1'b1,1'b0,34'h0,5'd1,   1'b1,34'h400,5'd1, 1'b0,1'b0,32'h0,2'b00,        1'b1,1'b0,34'h0,5'd1,   1'b0,1'b1,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};
        vecs[11] = '{1'b0,1'b0,34'h0,5'd0,   1'b1,34'h400,5'd1, 1'b0,1'b1,32'hBEAFDEAD,2'b00, 1'b0,1'b0,34'h0,5'd0,   1'b1,1'b1,1'b1,1'b0, 32'hBEAFDEAD,32'h0, 2'b00,2'b00};
        vecs[12] = '{1'b0,1'b0,34'h0,5'd0,   1'b1,34'h400,5'd0, 1'b0,1'b0,32'h0,2'b00,        1'b1,1'b0,34'h400,5'd1, 1'b1,1'b0,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};
        vecs[13] = '{1'b0,1'b0,34'h0,5'd0,   1'b0,34'h0,5'd0,   1'b0,1'b1,32'h77,2'b10,       1'b0,1'b0,34'h0,5'd0,   1'b1,1'b1,1'b0,1'b1, 32'h0,32'h77,       2'b00,2'b10};
        vecs[14] = '{1'b1,1'b1,34'h8,5'd1,   1'b0,34'h0,5'd0,   1'b1,1'b0,32'h0,2'b00,        1'b1,1'b0,34'h8,5'd1,   1'b1,1'b1,1'b0,1'b0, 32'h0,32'h0,        2'b00,2'b00};

        wdat[0] = 32'h1111_0001; wdat[1] = 32'h2222_0002; wdat[2] = 32'h3333_0003; wdat[3] = 32'h4444_0004;
        wbe[0]  = 4'hF;          wbe[1]  = 4'h3;          wbe[2]  = 4'hC;          wbe[3]  = 4'h1;

        // ---- reset values ----
        do_reset();
        @(negedge clk);
        chk("rst.m_read",   64'(m_read), 64'(0));
        chk("rst.m_write",  64'(m_write), 64'(0));
        chk("rst.m_addr",   64'(m_address), 64'(0));
        chk("rst.p0_wait",  64'(p0_waitrequest), 64'(1));
        chk("rst.p1_wait",  64'(p1_waitrequest), 64'(1));
        chk("rst.p0_rdv",   64'(p0_readdatavalid), 64'(0));
        chk("rst.p1_rdv",   64'(p1_readdatavalid), 64'(0));
        chk("rst.p0_rdata", 64'(p0_readdata), 64'(0));
        chk("rst.p0_resp",  64'(p0_response), 64'(0));

        // ---- vector table: arbitration, routing, READ_CMD lock, burstcount 0, read+write ----
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            p0_read = vecs[i].rd0; p0_write = vecs[i].wr0;
            p0_address = vecs[i].addr0; p0_burstcount = vecs[i].bc0;
            p1_read = vecs[i].rd1; p1_write = 1'b0;
            p1_address = vecs[i].addr1; p1_burstcount = vecs[i].bc1;
            m_waitrequest = vecs[i].mw; m_readdatavalid = vecs[i].rdv;
            m_readdata = vecs[i].rdata; m_response = vecs[i].resp;
            @(negedge clk);
            chk($sformatf("vec%0d.m_read", i),  64'(m_read), 64'(vecs[i].e_mrd));
            chk($sformatf("vec%0d.m_write", i), 64'(m_write), 64'(vecs[i].e_mwr));
            chk($sformatf("vec%0d.m_addr", i),  64'(m_address), 64'(vecs[i].e_maddr));
            chk($sformatf("vec%0d.m_bc", i),    64'(m_burstcount), 64'(vecs[i].e_mbc));
            chk($sformatf("vec%0d.p0_wait", i), 64'(p0_waitrequest), 64'(vecs[i].e_w0));
            chk($sformatf("vec%0d.p1_wait", i), 64'(p1_waitrequest), 64'(vecs[i].e_w1));
            chk($sformatf("vec%0d.p0_rdv", i),  64'(p0_readdatavalid), 64'(vecs[i].e_v0));
            chk($sformatf("vec%0d.p1_rdv", i),  64'(p1_readdatavalid), 64'(vecs[i].e_v1));
            chk($sformatf("vec%0d.p0_rdata", i), 64'(p0_readdata), 64'(vecs[i].e_d0));
            chk($sformatf("vec%0d.p1_rdata", i), 64'(p1_readdata), 64'(vecs[i].e_d1));
            chk($sformatf("vec%0d.p0_resp", i), 64'(p0_response), 64'(vecs[i].e_r0));
            chk($sformatf("vec%0d.p1_resp", i), 64'(p1_response), 64'(vecs[i].e_r1));
        end

        // ---- p1 16-beat read while p0 requests throughout ----
        do_reset();
        next_cycle();
        p1_read = 1'b1; p1_address = 34'h1000; p1_burstcount = 5'd16;
        @(negedge clk);
        chk("b16.cmd_m_read", 64'(m_read), 64'(1));
        chk("b16.cmd_m_bc",   64'(m_burstcount), 64'(16));
        chk("b16.cmd_p1_wait", 64'(p1_waitrequest), 64'(0));
        beats = 0;
        for (int i = 0; i < 40 && beats < 16; i++) begin
            next_cycle();
            p1_read = 1'b0;
            p0_read = 1'b1; p0_address = 34'h2000; p0_burstcount = 5'd1;
            m_readdatavalid = (i % 2 == 0);
            m_readdata = 32'hA000_0000 | 32'(beats);
            @(negedge clk);
            chk("b16.p0_rdv",  64'(p0_readdatavalid), 64'(0));
            chk("b16.p0_wait", 64'(p0_waitrequest), 64'(1));
            chk("b16.m_read",  64'(m_read), 64'(0));
            if (m_readdatavalid) begin
                chk("b16.p1_rdv",   64'(p1_readdatavalid), 64'(1));
                chk("b16.p1_rdata", 64'(p1_readdata), 64'(32'hA000_0000 | 32'(beats)));
                beats++;
            end
        end
        chk("b16.beats", 64'(beats), 64'(16));
        next_cycle();
        m_readdatavalid = 1'b0;
        @(negedge clk);
        chk("b16.p0_grant_m_read", 64'(m_read), 64'(1));
        chk("b16.p0_grant_addr",   64'(m_address), 64'(34'h2000));
        chk("b16.p0_grant_wait",   64'(p0_waitrequest), 64'(0));
        chk("b16.p1_rdv_after",    64'(p1_readdatavalid), 64'(0));

        // ---- p0 4-beat write with m_waitrequest toggling, p1 read held off ----
        do_reset();
        k = 0;
        for (int c = 0; c < 12 && k < 4; c++) begin
            next_cycle();
            p1_read = 1'b1; p1_address = 34'h3000; p1_burstcount = 5'd1;
            p0_write = 1'b1; p0_address = 34'h40; p0_burstcount = 5'd4;
            p0_writedata = wdat[k]; p0_byteenable = wbe[k];
            m_waitrequest = (c % 2 == 0);
            @(negedge clk);
            chk("wr.m_write", 64'(m_write), 64'(1));
            chk("wr.m_read",  64'(m_read), 64'(0));
            chk("wr.m_addr",  64'(m_address), 64'(34'h40));
            chk("wr.m_wdata", 64'(m_writedata), 64'(wdat[k]));
            chk("wr.m_be",    64'(m_byteenable), 64'(wbe[k]));
            chk("wr.p0_wait", 64'(p0_waitrequest), 64'((c % 2 == 0) ? 1 : 0));
            chk("wr.p1_wait", 64'(p1_waitrequest), 64'(1));
            if (!m_waitrequest) k++;
        end
        chk("wr.beats", 64'(k), 64'(4));
        next_cycle();
        p0_write = 1'b0; m_waitrequest = 1'b0;
        @(negedge clk);
        chk("wr.p1_grant_m_read", 64'(m_read), 64'(1));
        chk("wr.p1_grant_addr",   64'(m_address), 64'(34'h3000));
        chk("wr.p1_grant_wait",   64'(p1_waitrequest), 64'(0));

        // ---- 4-beat read with DECODEERROR on beat 2 ----
        do_reset();
        next_cycle();
        p0_read = 1'b1; p0_address = 34'h80; p0_burstcount = 5'd4;
        @(negedge clk);
        chk("err.cmd_m_read", 64'(m_read), 64'(1));
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            p0_read = 1'b0;
            m_readdatavalid = 1'b1;
            m_readdata = 32'hC0 + 32'(b);
            m_response = (b == 1) ? 2'b11 : 2'b00;
            @(negedge clk);
            chk("err.p0_rdv",   64'(p0_readdatavalid), 64'(1));
            chk("err.p0_rdata", 64'(p0_readdata), 64'(32'hC0 + 32'(b)));
            chk("err.p0_resp",  64'(p0_response), 64'((b == 1) ? 3 : 0));
        end
        next_cycle();
        m_readdatavalid = 1'b0; m_response = 2'b00;
        p1_read = 1'b1; p1_address = 34'h90; p1_burstcount = 5'd1;
        @(negedge clk);
        chk("err.idle_m_read", 64'(m_read), 64'(1));
        chk("err.idle_addr",   64'(m_address), 64'(34'h90));
        chk("err.idle_p1_wait", 64'(p1_waitrequest), 64'(0));

        // ---- async reset during READ_DATA ----
        do_reset();
        next_cycle();
        p0_read = 1'b1; p0_address = 34'h100; p0_burstcount = 5'd4;
        next_cycle();
        p0_read = 1'b0; m_readdatavalid = 1'b1; m_readdata = 32'hD0;
        @(negedge clk);
        chk("rstmid.pre_p0_rdv", 64'(p0_readdatavalid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid.p0_rdv",   64'(p0_readdatavalid), 64'(0));
        chk("rstmid.p0_rdata", 64'(p0_readdata), 64'(0));
        chk("rstmid.m_read",   64'(m_read), 64'(0));
        chk("rstmid.p0_wait",  64'(p0_waitrequest), 64'(1));
        chk("rstmid.p1_wait",  64'(p1_waitrequest), 64'(1));
        next_cycle();
        rst_n = 1'b1;
        clear_inputs();
        p0_read = 1'b1; p0_address = 34'h500; p0_burstcount = 5'd1;
        p1_read = 1'b1; p1_address = 34'h600; p1_burstcount = 5'd1;
        @(negedge clk);
        chk("rstmid.grant_addr", 64'(m_address), 64'(34'h500));
        chk("rstmid.p0_wait2",   64'(p0_waitrequest), 64'(0));
        chk("rstmid.p1_wait2",   64'(p1_waitrequest), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
